// File: rtl/control_unit_pkg.sv
// Shared definitions for the hardwired CPU controller: opcode values, controller
// states, instruction classes, the strobe bundle and a small ALU-select helper.
package control_unit_pkg;

  localparam int unsigned OpW = 5;   // opcode width, IR[31:27]
  localparam int unsigned IrW = 32;  // instruction width

  typedef logic [OpW-1:0] opcode_t;

  localparam opcode_t OpLd   = 5'b00000;
  localparam opcode_t OpLdi  = 5'b00001;
  localparam opcode_t OpSt   = 5'b00010;
  localparam opcode_t OpAdd  = 5'b00011;
  localparam opcode_t OpSub  = 5'b00100;
  localparam opcode_t OpAnd  = 5'b00101;
  localparam opcode_t OpOr   = 5'b00110;
  localparam opcode_t OpRor  = 5'b00111;
  localparam opcode_t OpRol  = 5'b01000;
  localparam opcode_t OpShr  = 5'b01001;
  localparam opcode_t OpShra = 5'b01010;
  localparam opcode_t OpShl  = 5'b01011;
  localparam opcode_t OpAddi = 5'b01100;
  localparam opcode_t OpAndi = 5'b01101;
  localparam opcode_t OpOri  = 5'b01110;
  localparam opcode_t OpDiv  = 5'b01111;
  localparam opcode_t OpMul  = 5'b10000;
  localparam opcode_t OpNeg  = 5'b10001;
  localparam opcode_t OpNot  = 5'b10010;
  localparam opcode_t OpBr   = 5'b10011;
  localparam opcode_t OpJr   = 5'b10100;
  localparam opcode_t OpJal  = 5'b10101;
  localparam opcode_t OpIn   = 5'b10110;
  localparam opcode_t OpOut  = 5'b10111;
  localparam opcode_t OpMfhi = 5'b11000;
  localparam opcode_t OpMflo = 5'b11001;
  localparam opcode_t OpNop  = 5'b11010;
  localparam opcode_t OpHalt = 5'b11011;

  // ALU select used for effective-address and branch-target adds
  localparam opcode_t AddOp = OpAdd;

  typedef enum logic [3:0] {
    StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_e;

  typedef enum logic [3:0] {
    ClsAluR, ClsAluI, ClsLd, ClsLdi, ClsSt, ClsMulDiv, ClsUnary,
    ClsBr, ClsJr, ClsJal, ClsIo, ClsMfx, ClsNop, ClsHalt
  } iclass_e;

  // One bit per datapath strobe
  typedef struct packed {
    logic pc_out;
    logic z_high_out;
    logic z_low_out;
    logic mdr_out;
    logic hi_out;
    logic lo_out;
    logic ba_out;
    logic in_port_out;
    logic c_out;
    logic mar_in;
    logic z_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic hi_in;
    logic lo_in;
    logic out_port_in;
    logic con_in;
    logic r15_in;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic inc_pc;
    logic read;
    logic write;
  } strobes_t;

  // Immediate forms reuse the register-form ALU function
  function automatic opcode_t alu_imm_op(opcode_t op);
    unique case (op)
      OpAndi:  return OpAnd;
      OpOri:   return OpOr;
      default: return OpAdd;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Controller <-> datapath connection bundle.
//   master: the controller (drives strobes, ALU_op, Run; sees IR, CON_FF, Stop)
//   slave : the datapath side (drives IR, CON_FF, Stop; sees strobes)
interface control_unit_if;

  logic [control_unit_pkg::IrW-1:0] IR;
  logic                             CON_FF;
  logic                             Stop;

  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin, R15in;
  logic Gra, Grb, Grc, Rin, Rout;
  logic IncPC, Read, Write;
  logic [control_unit_pkg::OpW-1:0] ALU_op;
  logic Run;

  modport master (
    input  IR, CON_FF, Stop,
    output PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin, R15in,
    output Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write, ALU_op, Run
  );

  modport slave (
    output IR, CON_FF, Stop,
    input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin, R15in,
    input  Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write, ALU_op, Run
  );

endinterface

// File: rtl/control_unit_instr_class.sv
// Combinational opcode -> instruction-class decode.
//   op_i  : IR[31:27]
//   cls_o : execute-sequence class; halt and reserved opcodes map to ClsHalt
module control_unit_instr_class
  import control_unit_pkg::*;
(
  input  opcode_t op_i,
  output iclass_e cls_o
);

  always_comb begin
    cls_o = ClsHalt;
    case (op_i) inside
      OpLd:            cls_o = ClsLd;
      OpLdi:           cls_o = ClsLdi;
      OpSt:            cls_o = ClsSt;
      [OpAdd:OpShl]:   cls_o = ClsAluR;
      [OpAddi:OpOri]:  cls_o = ClsAluI;
      OpDiv, OpMul:    cls_o = ClsMulDiv;
      OpNeg, OpNot:    cls_o = ClsUnary;
      OpBr:            cls_o = ClsBr;
      OpJr:            cls_o = ClsJr;
      OpJal:           cls_o = ClsJal;
      OpIn, OpOut:     cls_o = ClsIo;
      OpMfhi, OpMflo:  cls_o = ClsMfx;
      OpNop:           cls_o = ClsNop;
      default:         cls_o = ClsHalt;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore controller for the CPU datapath. Runs fetch T0-T2 and the
// per-opcode execute steps T3-T7, then returns to T0 (or HALT when Stop is set
// in the last step).
//   Clock : rising-edge clock
//   Reset : asynchronous active-low reset; forces RESET and all outputs low
//   cu_io : master side of control_unit_if (IR, CON_FF, Stop in; strobes,
//           ALU_op, Run out)
// Outputs are decoded from the state register and IR, so a reset clears them
// without waiting for a clock edge.
module control_unit
  import control_unit_pkg::*;
(
  input  logic           Clock,
  input  logic           Reset,
  control_unit_if.master cu_io
);

  state_e   state_q, state_d;
  opcode_t  op;
  iclass_e  cls;
  strobes_t strb;
  opcode_t  alu_op;
  logic     run;
  logic     last_step;
  logic     unused_ir;

  assign op        = cu_io.IR[IrW-1 -: OpW];
  assign unused_ir = ^cu_io.IR[IrW-OpW-1:0];

  control_unit_instr_class u_instr_class (
    .op_i  (op),
    .cls_o (cls)
  );

  // Final execute step of the current instruction
  always_comb begin
    last_step = 1'b0;
    unique case (state_q)
      StT3:    last_step = cls inside {ClsJr, ClsIo, ClsMfx, ClsNop};
      StT4:    last_step = cls inside {ClsUnary, ClsJal};
      StT5:    last_step = cls inside {ClsAluR, ClsAluI, ClsLdi};
      StT6:    last_step = cls inside {ClsMulDiv, ClsBr};
      StT7:    last_step = cls inside {ClsLd, ClsSt};
      default: last_step = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset: state_d = StT0;
      StT0:    state_d = StT1;
      StT1:    state_d = StT2;
      StT2:    state_d = StT3;
      StT3, StT4, StT5, StT6, StT7: begin
        if (state_q == StT3 && cls == ClsHalt) begin
          state_d = StHalt;
        end else if (last_step) begin
          state_d = cu_io.Stop ? StHalt : StT0;
        end else begin
          state_d = state_e'(state_q + 4'd1);
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StReset;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  // Output decode
  always_comb begin
    strb   = '0;
    alu_op = '0;
    unique case (state_q)
      StT0: begin
        strb.pc_out = 1'b1;
        strb.mar_in = 1'b1;
        strb.inc_pc = 1'b1;
        strb.z_in   = 1'b1;
      end
      StT1: begin
        strb.z_low_out = 1'b1;
        strb.pc_in     = 1'b1;
        strb.read      = 1'b1;
        strb.mdr_in    = 1'b1;
      end
      StT2: begin
        strb.mdr_out = 1'b1;
        strb.ir_in   = 1'b1;
      end
      StT3, StT4, StT5, StT6, StT7: begin
        unique case (cls)
          ClsAluR, ClsAluI: begin
            case (state_q)
              StT3: begin
                strb.grb = 1'b1; strb.r_out = 1'b1; strb.y_in = 1'b1;
              end
              StT4: begin
                if (cls == ClsAluI) begin
                  strb.c_out = 1'b1;
                  alu_op     = alu_imm_op(op);
                end else begin
                  strb.grc   = 1'b1;
                  strb.r_out = 1'b1;
                  alu_op     = op;
                end
                strb.z_in = 1'b1;
              end
              StT5: begin
                strb.z_low_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1;
              end
              default: ;
            endcase
          end
          ClsLd, ClsLdi, ClsSt: begin
            case (state_q)
              StT3: begin
                strb.grb = 1'b1; strb.ba_out = 1'b1; strb.y_in = 1'b1;
              end
              StT4: begin
                strb.c_out = 1'b1; strb.z_in = 1'b1;
                alu_op     = AddOp;
              end
              StT5: begin
                strb.z_low_out = 1'b1;
                if (cls == ClsLdi) begin
                  strb.gra = 1'b1; strb.r_in = 1'b1;
                end else begin
                  strb.mar_in = 1'b1;
                end
              end
              StT6: begin
                // Store loads MDR from the register file, so the MDR mux stays on the bus
                if (cls == ClsSt) begin
                  strb.gra = 1'b1; strb.r_out = 1'b1; strb.mdr_in = 1'b1;
                end else begin
                  strb.read = 1'b1; strb.mdr_in = 1'b1;
                end
              end
              StT7: begin
                if (cls == ClsSt) begin
                  strb.write = 1'b1;
                end else begin
                  strb.mdr_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1;
                end
              end
              default: ;
            endcase
          end
          ClsMulDiv: begin
            case (state_q)
              StT3: begin
                strb.gra = 1'b1; strb.r_out = 1'b1; strb.y_in = 1'b1;
              end
              StT4: begin
                strb.grb = 1'b1; strb.r_out = 1'b1; strb.z_in = 1'b1;
                alu_op   = op;
              end
              StT5: begin
                strb.z_low_out = 1'b1; strb.lo_in = 1'b1;
              end
              StT6: begin
                strb.z_high_out = 1'b1; strb.hi_in = 1'b1;
              end
              default: ;
            endcase
          end
          ClsUnary: begin
            case (state_q)
              StT3: begin
                // neg/not compute in T3, so the function select is driven there
                strb.grb = 1'b1; strb.r_out = 1'b1; strb.z_in = 1'b1;
                alu_op   = op;
              end
              StT4: begin
                strb.z_low_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1;
              end
              default: ;
            endcase
          end
          ClsBr: begin
            case (state_q)
              StT3: begin
                strb.gra = 1'b1; strb.r_out = 1'b1; strb.con_in = 1'b1;
              end
              StT4: begin
                strb.pc_out = 1'b1; strb.y_in = 1'b1;
              end
              StT5: begin
                strb.c_out = 1'b1; strb.z_in = 1'b1;
                alu_op     = AddOp;
              end
              StT6: begin
                // Not-taken branch idles through its last step
                if (cu_io.CON_FF) begin
                  strb.z_low_out = 1'b1; strb.pc_in = 1'b1;
                end
              end
              default: ;
            endcase
          end
          ClsJr: begin
            if (state_q == StT3) begin
              strb.gra = 1'b1; strb.r_out = 1'b1; strb.pc_in = 1'b1;
            end
          end
          ClsJal: begin
            case (state_q)
              StT3: begin
                strb.pc_out = 1'b1; strb.r15_in = 1'b1;
              end
              StT4: begin
                strb.gra = 1'b1; strb.r_out = 1'b1; strb.pc_in = 1'b1;
              end
              default: ;
            endcase
          end
          ClsIo: begin
            if (state_q == StT3) begin
              strb.gra = 1'b1;
              if (op == OpIn) begin
                strb.in_port_out = 1'b1; strb.r_in = 1'b1;
              end else begin
                strb.r_out = 1'b1; strb.out_port_in = 1'b1;
              end
            end
          end
          ClsMfx: begin
            if (state_q == StT3) begin
              strb.hi_out = (op == OpMfhi);
              strb.lo_out = (op != OpMfhi);
              strb.gra    = 1'b1;
              strb.r_in   = 1'b1;
            end
          end
          ClsNop, ClsHalt: ;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Run drops as soon as a halt opcode reaches T3
  assign run = (state_q inside {StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7}) &&
               !(state_q == StT3 && cls == ClsHalt);

  assign cu_io.PCout     = strb.pc_out;
  assign cu_io.Zhighout  = strb.z_high_out;
  assign cu_io.Zlowout   = strb.z_low_out;
  assign cu_io.MDRout    = strb.mdr_out;
  assign cu_io.HIout     = strb.hi_out;
  assign cu_io.LOout     = strb.lo_out;
  assign cu_io.BAout     = strb.ba_out;
  assign cu_io.InPortout = strb.in_port_out;
  assign cu_io.Cout      = strb.c_out;
  assign cu_io.MARin     = strb.mar_in;
  assign cu_io.Zin       = strb.z_in;
  assign cu_io.PCin      = strb.pc_in;
  assign cu_io.MDRin     = strb.mdr_in;
  assign cu_io.IRin      = strb.ir_in;
  assign cu_io.Yin       = strb.y_in;
  assign cu_io.HIin      = strb.hi_in;
  assign cu_io.LOin      = strb.lo_in;
  assign cu_io.OutPortin = strb.out_port_in;
  assign cu_io.CONin     = strb.con_in;
  assign cu_io.R15in     = strb.r15_in;
  assign cu_io.Gra       = strb.gra;
  assign cu_io.Grb       = strb.grb;
  assign cu_io.Grc       = strb.grc;
  assign cu_io.Rin       = strb.r_in;
  assign cu_io.Rout      = strb.r_out;
  assign cu_io.IncPC     = strb.inc_pc;
  assign cu_io.Read      = strb.read;
  assign cu_io.Write     = strb.write;
  assign cu_io.ALU_op    = alu_op;
  assign cu_io.Run       = run;

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit: one row per clock cycle with
// hand-computed strobe/ALU_op/Run expectations, plus hand sequences for halt,
// reset-release timing and an asynchronous reset during a store.
module tb_control_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  control_unit_if cu_if ();

  control_unit u_dut (
    .Clock (clk),
    .Reset (rst_n),
    .cu_io (cu_if)
  );

  // Bench-side strobe bit positions
  localparam logic [27:0] SPcOut   = 28'd1 << 0;
  localparam logic [27:0] SZhOut   = 28'd1 << 1;
  localparam logic [27:0] SZlOut   = 28'd1 << 2;
  localparam logic [27:0] SMdrOut  = 28'd1 << 3;
  localparam logic [27:0] SHiOut   = 28'd1 << 4;
  localparam logic [27:0] SLoOut   = 28'd1 << 5;
  localparam logic [27:0] SBaOut   = 28'd1 << 6;
  localparam logic [27:0] SInPOut  = 28'd1 << 7;
  localparam logic [27:0] SCOut    = 28'd1 << 8;
  localparam logic [27:0] SMarIn   = 28'd1 << 9;
  localparam logic [27:0] SZIn     = 28'd1 << 10;
  localparam logic [27:0] SPcIn    = 28'd1 << 11;
  localparam logic [27:0] SMdrIn   = 28'd1 << 12;
  localparam logic [27:0] SIrIn    = 28'd1 << 13;
  localparam logic [27:0] SYIn     = 28'd1 << 14;
  localparam logic [27:0] SHiIn    = 28'd1 << 15;
  localparam logic [27:0] SLoIn    = 28'd1 << 16;
  localparam logic [27:0] SOutPIn  = 28'd1 << 17;
  localparam logic [27:0] SConIn   = 28'd1 << 18;
  localparam logic [27:0] SR15In   = 28'd1 << 19;
  localparam logic [27:0] SGra     = 28'd1 << 20;
  localparam logic [27:0] SGrb     = 28'd1 << 21;
  localparam logic [27:0] SGrc     = 28'd1 << 22;
  localparam logic [27:0] SRin     = 28'd1 << 23;
  localparam logic [27:0] SRout    = 28'd1 << 24;
  localparam logic [27:0] SIncPc   = 28'd1 << 25;
  localparam logic [27:0] SRead    = 28'd1 << 26;
  localparam logic [27:0] SWrite   = 28'd1 << 27;

  typedef struct {
    string       tag;
    logic [31:0] ir;
    logic        con_ff;
    logic        stop;
    logic [27:0] strb;
    logic [4:0]  alu;
    logic        run;
  } row_t;

  row_t rows[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [27:0] act_strb();
    return {cu_if.Write, cu_if.Read, cu_if.IncPC, cu_if.Rout, cu_if.Rin, cu_if.Grc,
            cu_if.Grb, cu_if.Gra, cu_if.R15in, cu_if.CONin, cu_if.OutPortin, cu_if.LOin,
            cu_if.HIin, cu_if.Yin, cu_if.IRin, cu_if.MDRin, cu_if.PCin, cu_if.Zin,
            cu_if.MARin, cu_if.Cout, cu_if.InPortout, cu_if.BAout, cu_if.LOout,
            cu_if.HIout, cu_if.MDRout, cu_if.Zlowout, cu_if.Zhighout, cu_if.PCout};
  endfunction

  task automatic check(string tag, logic [27:0] es, logic [4:0] ea, logic er);
    logic [27:0] as;
    as = act_strb();
    checks++;
    if (as !== es || cu_if.ALU_op !== ea || cu_if.Run !== er) begin
      errors++;
      $display("FAIL %s: got strobes=%h alu=%b run=%b, want strobes=%h alu=%b run=%b",
               tag, as, cu_if.ALU_op, cu_if.Run, es, ea, er);
    end
  endtask

  function automatic void add_row(string tag, logic [31:0] ir, logic con_ff, logic stop,
                                  logic [27:0] s, logic [4:0] alu, logic run);
    row_t r;
    r.tag = tag; r.ir = ir; r.con_ff = con_ff; r.stop = stop;
    r.strb = s; r.alu = alu; r.run = run;
    rows.push_back(r);
  endfunction

  function automatic void add_fetch(string tag, logic [31:0] ir, logic con_ff);
    add_row({tag, "/T0"}, ir, con_ff, 1'b0, SPcOut | SMarIn | SIncPc | SZIn, 5'd0, 1'b1);
    add_row({tag, "/T1"}, ir, con_ff, 1'b0, SZlOut | SPcIn | SRead | SMdrIn, 5'd0, 1'b1);
    add_row({tag, "/T2"}, ir, con_ff, 1'b0, SMdrOut | SIrIn, 5'd0, 1'b1);
  endfunction

  function automatic void add_alu_r(string tag, logic [31:0] ir, logic [4:0] alu);
    add_fetch(tag, ir, 1'b0);
    add_row({tag, "/T3"}, ir, 1'b0, 1'b0, SGrb | SRout | SYIn, 5'd0, 1'b1);
    add_row({tag, "/T4"}, ir, 1'b0, 1'b0, SGrc | SRout | SZIn, alu, 1'b1);
    add_row({tag, "/T5"}, ir, 1'b0, 1'b0, SZlOut | SGra | SRin, 5'd0, 1'b1);
  endfunction

  // stop_mask bit k sets Stop during step T(3+k)
  function automatic void add_alu_i(string tag, logic [31:0] ir, logic [4:0] alu,
                                    logic [2:0] stop_mask);
    add_fetch(tag, ir, 1'b0);
    add_row({tag, "/T3"}, ir, 1'b0, stop_mask[0], SGrb | SRout | SYIn, 5'd0, 1'b1);
    add_row({tag, "/T4"}, ir, 1'b0, stop_mask[1], SCOut | SZIn, alu, 1'b1);
    add_row({tag, "/T5"}, ir, 1'b0, stop_mask[2], SZlOut | SGra | SRin, 5'd0, 1'b1);
  endfunction

  function automatic void add_mem_addr(string tag, logic [31:0] ir);
    add_fetch(tag, ir, 1'b0);
    add_row({tag, "/T3"}, ir, 1'b0, 1'b0, SGrb | SBaOut | SYIn, 5'd0, 1'b1);
    add_row({tag, "/T4"}, ir, 1'b0, 1'b0, SCOut | SZIn, 5'b00011, 1'b1);
    add_row({tag, "/T5"}, ir, 1'b0, 1'b0, SZlOut | SMarIn, 5'd0, 1'b1);
  endfunction

  function automatic void add_br(string tag, logic con_ff);
    logic [31:0] ir;
    ir = 32'h98000000;
    add_fetch(tag, ir, con_ff);
    add_row({tag, "/T3"}, ir, con_ff, 1'b0, SGra | SRout | SConIn, 5'd0, 1'b1);
    add_row({tag, "/T4"}, ir, con_ff, 1'b0, SPcOut | SYIn, 5'd0, 1'b1);
    add_row({tag, "/T5"}, ir, con_ff, 1'b0, SCOut | SZIn, 5'b00011, 1'b1);
    add_row({tag, "/T6"}, ir, con_ff, 1'b0, con_ff ? (SZlOut | SPcIn) : 28'd0, 5'd0, 1'b1);
  endfunction

  // Inputs change on the falling edge; outputs are compared 1 ns later
  task automatic run_rows();
    foreach (rows[i]) begin
      @(negedge clk);
      cu_if.IR     = rows[i].ir;
      cu_if.CON_FF = rows[i].con_ff;
      cu_if.Stop   = rows[i].stop;
      #1;
      check(rows[i].tag, rows[i].strb, rows[i].alu, rows[i].run);
    end
    rows.delete();
  endtask

  task automatic reset_pulse(string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check({tag, "/asserted"}, 28'd0, 5'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check({tag, "/released"}, 28'd0, 5'd0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    cu_if.IR     = 32'h0;
    cu_if.CON_FF = 1'b0;
    cu_if.Stop   = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_state", 28'd0, 5'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Per-cycle vector table
    add_alu_r("add", 32'h18000000, 5'b00011);
    add_alu_r("shl", 32'h58000000, 5'b01011);
    add_alu_i("addi_stop_early", 32'h611FFFFD, 5'b00011, 3'b011);
    add_alu_i("ori", 32'h70000000, 5'b00110, 3'b000);
    add_mem_addr("ld", 32'h00800055);
    add_row("ld/T6", 32'h00800055, 1'b0, 1'b0, SRead | SMdrIn, 5'd0, 1'b1);
    add_row("ld/T7", 32'h00800055, 1'b0, 1'b0, SMdrOut | SGra | SRin, 5'd0, 1'b1);
    add_br("br_nt", 1'b0);
    add_br("br_t", 1'b1);
    add_fetch("mul", 32'h80000000, 1'b0);
    add_row("mul/T3", 32'h80000000, 1'b0, 1'b0, SGra | SRout | SYIn, 5'd0, 1'b1);
    add_row("mul/T4", 32'h80000000, 1'b0, 1'b0, SGrb | SRout | SZIn, 5'b10000, 1'b1);
    add_row("mul/T5", 32'h80000000, 1'b0, 1'b0, SZlOut | SLoIn, 5'd0, 1'b1);
    add_row("mul/T6", 32'h80000000, 1'b0, 1'b0, SZhOut | SHiIn, 5'd0, 1'b1);
    add_fetch("jal", 32'hA8000000, 1'b0);
    add_row("jal/T3", 32'hA8000000, 1'b0, 1'b0, SPcOut | SR15In, 5'd0, 1'b1);
    add_row("jal/T4", 32'hA8000000, 1'b0, 1'b0, SGra | SRout | SPcIn, 5'd0, 1'b1);
    add_fetch("mfhi", 32'hC0000000, 1'b0);
    add_row("mfhi/T3", 32'hC0000000, 1'b0, 1'b0, SHiOut | SGra | SRin, 5'd0, 1'b1);
    add_fetch("nop", 32'hD0000000, 1'b0);
    add_row("nop/T3", 32'hD0000000, 1'b0, 1'b0, 28'd0, 5'd0, 1'b1);
    add_mem_addr("st", 32'h10000000);
    add_row("st/T6", 32'h10000000, 1'b0, 1'b0, SGra | SRout | SMdrIn, 5'd0, 1'b1);
    add_row("st/T7", 32'h10000000, 1'b0, 1'b0, SWrite, 5'd0, 1'b1);
    add_alu_i("addi_stop", 32'h611FFFFD, 5'b00011, 3'b100);
    for (int k = 0; k < 3; k++) begin
      add_row("stop_halt", 32'h611FFFFD, 1'b0, 1'b0, 28'd0, 5'd0, 1'b0);
    end
    run_rows();

    // Halt opcode: Run drops in T3 and stays low until reset
    reset_pulse("rst1");
    add_fetch("halt", 32'hD8000000, 1'b0);
    add_row("halt/T3", 32'hD8000000, 1'b0, 1'b0, 28'd0, 5'd0, 1'b0);
    run_rows();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      check("halt_hold", 28'd0, 5'd0, 1'b0);
    end
    reset_pulse("rst2");
    @(negedge clk);
    #1;
    check("first_edge_T0", SPcOut | SMarIn | SIncPc | SZIn, 5'd0, 1'b1);

    // Asynchronous reset in the middle of a store's write cycle
    reset_pulse("rst3");
    add_mem_addr("st2", 32'h10000000);
    add_row("st2/T6", 32'h10000000, 1'b0, 1'b0, SGra | SRout | SMdrIn, 5'd0, 1'b1);
    add_row("st2/T7", 32'h10000000, 1'b0, 1'b0, SWrite, 5'd0, 1'b1);
    run_rows();
    #2 rst_n = 1'b0;
    #1;
    check("st_abort_no_edge", 28'd0, 5'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
